// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the 16x-oversampled UART
//               receive path (state encoding, oversampling geometry,
//               default frame format).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, explicitly 2-bit encoded
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    // Oversampling ticks per bit period and the tick index of mid start bit
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Default frame format: 8 data bits, one stop bit
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchroniser for a single asynchronous
//               input. Both flops reset to RESET_VAL so an idle-high line
//               does not present a spurious edge when reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; the first stage may go metastable, the second is used
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : UART receiver driven by a 16x oversampling tick. Finds the
//               start bit, samples DBIT data bits LSB first at mid-bit,
//               checks the stop bit and presents each word with a one-clock
//               done strobe and a framing-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    // Bit-counter width; DBIT is at least 5 so $clog2 is never below 3
    localparam int c_NW = $clog2(DBIT);

    localparam logic [4:0]      c_S_MID      = 5'(MID_TICK);
    localparam logic [4:0]      c_S_BIT_END  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]      c_S_STOP_END = 5'(SB_TICK - 1);
    localparam logic [4:0]      c_S_ONE      = 5'd1;
    localparam logic [c_NW-1:0] c_N_LAST     = c_NW'(DBIT - 1);
    localparam logic [c_NW-1:0] c_N_ONE      = c_NW'(1);

    logic            w_rx_s;

    state_t          r_state;
    logic [4:0]      r_s;
    logic [c_NW-1:0] r_n;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;

    state_t          w_state;
    logic [4:0]      w_s;
    logic [c_NW-1:0] w_n;
    logic [DBIT-1:0] w_b;
    logic [DBIT-1:0] w_dout;
    logic            w_done;
    logic            w_ferr;

    // rx is asynchronous to clk; the FSM only ever looks at the synchronised copy
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_n     <= w_n;
            r_b     <= w_b;
            r_dout  <= w_dout;
            r_done  <= w_done;
            r_ferr  <= w_ferr;
        end
    end

    // Next-state and datapath: everything holds unless a tick advances it
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_n     = r_n;
        w_b     = r_b;
        w_dout  = r_dout;
        w_ferr  = r_ferr;
        w_done  = 1'b0;

        case (r_state)
            IDLE: begin
                // Start edge is taken immediately so back-to-back frames lose no tick
                if (!w_rx_s) begin
                    w_state = START;
                    w_s     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (r_s == c_S_MID) begin
                        // Still low at mid start bit: genuine start, else a glitch
                        if (!w_rx_s) begin
                            w_state = DATA;
                            w_s     = '0;
                            w_n     = '0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_s = r_s + c_S_ONE;
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (r_s == c_S_BIT_END) begin
                        // One full bit after the previous mid-point: sample, LSB first
                        w_s = '0;
                        w_b = {w_rx_s, r_b[DBIT-1:1]};
                        if (r_n == c_N_LAST) begin
                            w_state = STOP;
                        end else begin
                            w_n = r_n + c_N_ONE;
                        end
                    end else begin
                        w_s = r_s + c_S_ONE;
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (r_s == c_S_STOP_END) begin
                        // Word is delivered even on a bad stop bit, flagged via frame_err
                        w_done  = 1'b1;
                        w_dout  = r_b;
                        w_ferr  = ~w_rx_s;
                        w_state = IDLE;
                    end else begin
                        w_s = r_s + c_S_ONE;
                    end
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign busy         = (r_state != IDLE);

endmodule : uart_rx_os
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Self-checking bench for uart_rx_os. Two receivers share the
//               clock, reset and oversampling tick: dut_a uses one stop bit
//               (SB_TICK=16), dut_b two (SB_TICK=32). Frames are built in
//               units of s_tick; a frame-level model predicts each word, its
//               framing flag and its tick latency from the rx falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int DBIT = 8;
    localparam int SB_A = 16;
    localparam int SB_B = 32;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx_a   = 1'b1;
    logic       rx_b   = 1'b1;
    logic       s_tick = 1'b0;
    logic       hold   = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic       done_a, done_b, ferr_a, ferr_b, busy_a, busy_b;

    int unsigned tdiv     = 0;
    int unsigned consumed = 0;

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level model, index 0 = dut_a, 1 = dut_b
    bit          pend      [2];
    logic [7:0]  pend_data [2];
    bit          pend_ferr [2];
    int unsigned pend_mark [2];
    logic [7:0]  last_dout [2];
    bit          last_ferr [2];
    int unsigned last_lat  [2];
    int          strobes   [2];

    always #5 clk = ~clk;

    // One-clock s_tick every 4 clk, suppressed while hold is set; count ticks the DUTs consume
    always @(posedge clk) begin
        tdiv   <= (tdiv == 3) ? 0 : tdiv + 1;
        s_tick <= (tdiv == 3) && !hold;
        if (s_tick) consumed <= consumed + 1;
    end

    uart_rx_os #(.DBIT(DBIT), .SB_TICK(SB_A)) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick),
        .dout(dout_a), .rx_done_tick(done_a), .frame_err(ferr_a), .busy(busy_a)
    );

    uart_rx_os #(.DBIT(DBIT), .SB_TICK(SB_B)) dut_b (
        .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick),
        .dout(dout_b), .rx_done_tick(done_b), .frame_err(ferr_b), .busy(busy_b)
    );

    function automatic int unsigned lat(input int id);
        return 8 + 16 * DBIT + ((id == 1) ? SB_B : SB_A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_one(input int id, input logic done, input logic [7:0] d, input logic fe);
        if (done === 1'b1) begin
            if (!pend[id]) begin
                chk(id ? "b_strobe_without_frame" : "a_strobe_without_frame",
                    32'(done), 32'(pend[id]));
            end else begin
                last_dout[id] = pend_data[id];
                last_ferr[id] = pend_ferr[id];
                last_lat[id]  = consumed - pend_mark[id] - 1;
                pend[id]      = 1'b0;
                strobes[id]++;
                chk(id ? "b_latency" : "a_latency", last_lat[id], lat(id));
            end
        end else if (done !== 1'b0) begin
            chk(id ? "b_done_unknown" : "a_done_unknown", 32'(done), 32'(1'b0));
        end
        chk(id ? "b_dout" : "a_dout", 32'(d), 32'(last_dout[id]));
        chk(id ? "b_frame_err" : "a_frame_err", 32'(fe), 32'(last_ferr[id]));
    endtask

    task automatic set_rx(input int id, input logic v);
        if (id == 0) rx_a = v;
        else         rx_b = v;
    endtask

    // Advance to the falling clk edge of the n-th next tick
    task automatic wait_ticks(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (s_tick !== 1'b1 && guard < 200);
            if (guard >= 200) begin
                $display("FAIL tick_timeout: got no s_tick within %0d clk", guard);
                $fatal(1);
            end
        end
    endtask

    task automatic idle(input int id, input int n);
        set_rx(id, 1'b1);
        wait_ticks(n);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            pend[k]      = 1'b0;
            last_dout[k] = 8'h00;
            last_ferr[k] = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Send one frame, starting on the current tick edge. abort_bit pulses reset
    // mid-way through that data bit; hold_bit withholds s_tick for 50 clk inside it.
    task automatic send_frame(input int id, input logic [7:0] data, input bit stop_ok,
                              input int abort_bit, input int hold_bit);
        int sb;
        sb = (id == 1) ? SB_B : SB_A;
        chk(id ? "b_previous_frame_missing" : "a_previous_frame_missing", 32'(pend[id]), 32'(1'b0));
        if (abort_bit < 0) begin
            pend[id]      = 1'b1;
            pend_data[id] = data;
            pend_ferr[id] = !stop_ok;
            pend_mark[id] = consumed;
        end
        set_rx(id, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            set_rx(id, data[i]);
            if (i == abort_bit) begin
                wait_ticks(8);
                pulse_reset();
                set_rx(id, 1'b1);
                return;
            end
            if (i == hold_bit) begin
                wait_ticks(5);
                hold = 1'b1;
                repeat (50) @(negedge clk);
                chk(id ? "b_busy_during_hold" : "a_busy_during_hold",
                    32'(id ? busy_b : busy_a), 32'(1'b1));
                hold = 1'b0;
                wait_ticks(11);
            end else begin
                wait_ticks(16);
            end
        end
        if (stop_ok) begin
            set_rx(id, 1'b1);
            wait_ticks(sb);
        end else begin
            set_rx(id, 1'b0);
            wait_ticks(sb - 4);
            set_rx(id, 1'b1);
            wait_ticks(4);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [7:0] rd;
        bit ok;
        int hb;

        for (int k = 0; k < 2; k++) begin
            pend[k] = 1'b0; pend_data[k] = 8'h00; pend_ferr[k] = 1'b0; pend_mark[k] = 0;
            last_dout[k] = 8'h00; last_ferr[k] = 1'b0; last_lat[k] = 0; strobes[k] = 0;
        end

        // Compare process: every cycle, both receivers against the model
        fork
            forever begin
                @(negedge clk);
                cmp_one(0, done_a, dout_a, ferr_a);
                cmp_one(1, done_b, dout_b, ferr_b);
            end
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_dout_a", 32'(dout_a), 32'h00);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_ferr_a", 32'(ferr_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h0);
        chk("rst_dout_b", 32'(dout_b), 32'h00);
        chk("rst_busy_b", 32'(busy_b), 32'h0);

        wait_ticks(1);
        idle(0, 16);

        // Single byte
        send_frame(0, 8'hA5, 1'b1, -1, -1);
        chk("a5_received", 32'(pend[0]), 32'h0);
        chk("a5_dout", 32'(dout_a), 32'hA5);
        chk("a5_frame_err", 32'(ferr_a), 32'h0);
        chk("a5_busy_after", 32'(busy_a), 32'h0);
        chk("a5_strobe_count", 32'(strobes[0]), 32'd1);
        chk("a5_latency_ticks", last_lat[0], 32'd152);

        // Glitch rejection: low for 3 ticks only
        s0 = strobes[0];
        set_rx(0, 1'b0);
        wait_ticks(3);
        set_rx(0, 1'b1);
        wait_ticks(12);
        chk("glitch_busy", 32'(busy_a), 32'h0);
        chk("glitch_dout_kept", 32'(dout_a), 32'hA5);
        chk("glitch_no_strobe", 32'(strobes[0] - s0), 32'd0);

        // Framing error, then a clean frame clears the flag
        send_frame(0, 8'h3C, 1'b0, -1, -1);
        chk("fe_dout", 32'(dout_a), 32'h3C);
        chk("fe_flag", 32'(ferr_a), 32'h1);
        idle(0, 16);
        send_frame(0, 8'h55, 1'b1, -1, -1);
        chk("fe_clear_dout", 32'(dout_a), 32'h55);
        chk("fe_clear_flag", 32'(ferr_a), 32'h0);

        // Back-to-back, zero idle gap
        s0 = strobes[0];
        send_frame(0, 8'h00, 1'b1, -1, -1);
        send_frame(0, 8'hFF, 1'b1, -1, -1);
        send_frame(0, 8'h81, 1'b1, -1, -1);
        chk("b2b_strobes", 32'(strobes[0] - s0), 32'd3);
        chk("b2b_last_dout", 32'(dout_a), 32'h81);

        // Reset during data bit 4
        idle(0, 16);
        s0 = strobes[0];
        send_frame(0, 8'h96, 1'b1, 4, -1);
        @(negedge clk);
        chk("rstmid_dout_a", 32'(dout_a), 32'h00);
        chk("rstmid_ferr_a", 32'(ferr_a), 32'h0);
        chk("rstmid_done_a", 32'(done_a), 32'h0);
        chk("rstmid_busy_a", 32'(busy_a), 32'h0);
        chk("rstmid_no_strobe", 32'(strobes[0] - s0), 32'd0);
        wait_ticks(1);
        idle(0, 20);
        send_frame(0, 8'h96, 1'b1, -1, -1);
        chk("rstmid_resend", 32'(dout_a), 32'h96);

        // Two stop bits with s_tick withheld for 50 clk inside data bit 3
        send_frame(1, 8'hC3, 1'b1, -1, 3);
        idle(1, 16);
        chk("sb32_received", 32'(pend[1]), 32'h0);
        chk("sb32_dout", 32'(dout_b), 32'hC3);
        chk("sb32_frame_err", 32'(ferr_b), 32'h0);
        chk("sb32_busy_after", 32'(busy_b), 32'h0);
        chk("sb32_latency_ticks", last_lat[1], 32'd168);

        // Randomised frames on the one-stop-bit receiver
        for (int f = 0; f < 12; f++) begin
            rd = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(0, rd, ok, -1, -1);
            chk("rand_a_received", 32'(pend[0]), 32'h0);
            if (!ok) idle(0, 16);
            else     idle(0, 8 * $urandom_range(0, 2));
        end

        // Randomised frames on the two-stop-bit receiver, some with tick gaps
        for (int f = 0; f < 6; f++) begin
            rd = 8'($urandom);
            hb = $urandom_range(0, 11);
            if (hb >= DBIT) hb = -1;
            send_frame(1, rd, 1'b1, -1, hb);
            idle(1, 16);
            chk("rand_b_received", 32'(pend[1]), 32'h0);
            chk("rand_b_busy", 32'(busy_b), 32'h0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_rx_os
`default_nettype wire
